// File: rtl/roi_ctrl_pkg.sv
// Shared types and constants for the ROI capture controller:
// FSM states, config register map and CTRL bit positions.
package roi_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_X0   = 2'd0;
    localparam logic [1:0] ADDR_Y0   = 2'd1;
    localparam logic [1:0] ADDR_SIZE = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_AUTO = 0;
    localparam int CTRL_CONT = 1;
    localparam int CTRL_CLR  = 7;

    localparam logic [15:0] ROI_DEF_SIZE = 16'd224;

endpackage

// File: rtl/roi_capture_ctrl_if.sv
// Bundles the sync/counter inputs, host config bus, capture control and
// pixel-writer outputs of the ROI capture controller.
interface roi_capture_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             VS, HS, DE;
    logic [CNT_W-1:0] H_CNT, V_CNT;
    logic             CFG_WE;
    logic [1:0]       CFG_ADDR;
    logic [15:0]      CFG_WDATA;
    logic             START, ABORT, WR_READY;
    logic             PIX_WE;
    logic [CNT_W-1:0] PIX_X, PIX_Y;
    logic             BUSY, CAP_DONE, ERR_TO, ERR_OVF;
    logic [CNT_W-1:0] H_LEN, V_LEN;
    logic [7:0]       FRAME_CNT;

    modport master (
        output VS, HS, DE, H_CNT, V_CNT, CFG_WE, CFG_ADDR, CFG_WDATA,
               START, ABORT, WR_READY,
        input  PIX_WE, PIX_X, PIX_Y, BUSY, CAP_DONE, ERR_TO, ERR_OVF,
               H_LEN, V_LEN, FRAME_CNT
    );

    modport slave (
        input  VS, HS, DE, H_CNT, V_CNT, CFG_WE, CFG_ADDR, CFG_WDATA,
               START, ABORT, WR_READY,
        output PIX_WE, PIX_X, PIX_Y, BUSY, CAP_DONE, ERR_TO, ERR_OVF,
               H_LEN, V_LEN, FRAME_CNT
    );

endinterface

// File: rtl/roi_cfg_regs.sv
// Host-visible staging registers and the frame-synchronous shadow copy used
// by the window logic; shadows only change on a VS rising edge.
module roi_cfg_regs
    import roi_ctrl_pkg::*;
#(
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] DEF_X0   = '0,
    parameter logic [CNT_W-1:0] DEF_Y0   = '0,
    parameter logic [CNT_W-1:0] DEF_SIZE = CNT_W'(ROI_DEF_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    input  logic             vs_rise,
    input  logic [CNT_W-1:0] h_len,
    input  logic [CNT_W-1:0] v_len,
    output logic [CNT_W-1:0] x0s,
    output logic [CNT_W-1:0] y0s,
    output logic [CNT_W-1:0] sizes,
    output logic             conts,
    output logic             clr_flags
);

    logic [CNT_W-1:0] x0_reg, y0_reg, size_reg;
    logic             auto_reg, cont_reg;
    logic [CNT_W-1:0] x0s_reg, y0s_reg, sizes_reg;
    logic             conts_reg;

    // Centre offset len/2 - size/2, clamped at zero when the ROI is larger than the frame.
    function automatic logic [CNT_W-1:0] center_off(input logic [CNT_W-1:0] len,
                                                    input logic [CNT_W-1:0] size);
        logic [CNT_W-1:0] half_len, half_size;
        half_len  = len >> 1;
        half_size = size >> 1;
        return (half_len >= half_size) ? (half_len - half_size) : '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_reg   <= DEF_X0;
            y0_reg   <= DEF_Y0;
            size_reg <= DEF_SIZE;
            auto_reg <= 1'b0;
            cont_reg <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_X0:   x0_reg   <= CNT_W'(cfg_wdata);
                ADDR_Y0:   y0_reg   <= CNT_W'(cfg_wdata);
                ADDR_SIZE: size_reg <= CNT_W'(cfg_wdata);
                default: begin
                    auto_reg <= cfg_wdata[CTRL_AUTO];
                    cont_reg <= cfg_wdata[CTRL_CONT];
                end
            endcase
        end
    end

    // h_len/v_len are the registered values, i.e. the measurement before this edge's update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0s_reg   <= DEF_X0;
            y0s_reg   <= DEF_Y0;
            sizes_reg <= DEF_SIZE;
            conts_reg <= 1'b0;
        end else if (vs_rise) begin
            x0s_reg   <= auto_reg ? center_off(h_len, size_reg) : x0_reg;
            y0s_reg   <= auto_reg ? center_off(v_len, size_reg) : y0_reg;
            sizes_reg <= size_reg;
            conts_reg <= cont_reg;
        end
    end

    assign x0s       = x0s_reg;
    assign y0s       = y0s_reg;
    assign sizes     = sizes_reg;
    assign conts     = conts_reg;
    assign clr_flags = cfg_we & (cfg_addr == ADDR_CTRL) & cfg_wdata[CTRL_CLR];

endmodule

// File: rtl/roi_capture_ctrl.sv
// Frame-level ROI capture controller: measures frame size, runs the
// IDLE/ARM/CAPTURE sequencer with a sync watchdog, and gates pixel writes.
module roi_capture_ctrl
    import roi_ctrl_pkg::*;
#(
    parameter int               CNT_W    = 16,
    parameter int               TO_W     = 24,
    parameter logic [TO_W-1:0]  TIMEOUT  = TO_W'(24'd2000000),
    parameter logic [CNT_W-1:0] DEF_X0   = '0,
    parameter logic [CNT_W-1:0] DEF_Y0   = '0,
    parameter logic [CNT_W-1:0] DEF_SIZE = CNT_W'(ROI_DEF_SIZE)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    roi_capture_ctrl_if.slave  bus
);

    logic             hs_d_reg, vs_d_reg, hs_rise, vs_rise;
    logic [CNT_W-1:0] h_len_reg, v_len_reg;
    logic [CNT_W-1:0] x0s, y0s, sizes;
    logic             conts, clr_flags;
    logic [CNT_W:0]   x_end, y_end;
    logic             in_win;
    state_t           state_reg, state_next;
    logic [TO_W-1:0]  wd_reg;
    logic             busy, capturing, cap_evt, to_hit, pix_hit;
    logic             pix_we_reg, cap_done_reg, err_to_reg, err_ovf_reg;
    logic [CNT_W-1:0] pix_x_reg, pix_y_reg;
    logic [7:0]       frame_cnt_reg;

    assign hs_rise = bus.HS & ~hs_d_reg;
    assign vs_rise = bus.VS & ~vs_d_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_d_reg  <= 1'b0;
            vs_d_reg  <= 1'b0;
            h_len_reg <= '0;
            v_len_reg <= '0;
        end else begin
            hs_d_reg <= bus.HS;
            vs_d_reg <= bus.VS;
            if (hs_rise) h_len_reg <= bus.H_CNT;
            if (vs_rise) v_len_reg <= bus.V_CNT;
        end
    end

    roi_cfg_regs #(
        .CNT_W    (CNT_W),
        .DEF_X0   (DEF_X0),
        .DEF_Y0   (DEF_Y0),
        .DEF_SIZE (DEF_SIZE)
    ) u_cfg (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .cfg_we    (bus.CFG_WE),
        .cfg_addr  (bus.CFG_ADDR),
        .cfg_wdata (bus.CFG_WDATA),
        .vs_rise   (vs_rise),
        .h_len     (h_len_reg),
        .v_len     (v_len_reg),
        .x0s       (x0s),
        .y0s       (y0s),
        .sizes     (sizes),
        .conts     (conts),
        .clr_flags (clr_flags)
    );

    // One extra bit on the window end so X0+SIZE near full scale cannot wrap.
    assign x_end  = {1'b0, x0s} + {1'b0, sizes};
    assign y_end  = {1'b0, y0s} + {1'b0, sizes};
    assign in_win = (bus.H_CNT >= x0s) & ({1'b0, bus.H_CNT} < x_end) &
                    (bus.V_CNT >= y0s) & ({1'b0, bus.V_CNT} < y_end);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.START) state_next = ARM;
            ARM:     if (vs_rise) state_next = CAPTURE;
            CAPTURE: if (vs_rise && !conts) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (to_hit)    state_next = IDLE;
        if (bus.ABORT) state_next = IDLE;
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        capturing = (state_reg == CAPTURE);
        cap_evt   = capturing & vs_rise & ~bus.ABORT;
        to_hit    = busy & ~vs_rise & (wd_reg == TIMEOUT - 1'b1);
        pix_hit   = capturing & bus.DE & in_win;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)            wd_reg <= '0;
        else if (!busy || vs_rise) wd_reg <= '0;
        else                     wd_reg <= wd_reg + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_we_reg    <= 1'b0;
            pix_x_reg     <= '0;
            pix_y_reg     <= '0;
            cap_done_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            err_to_reg    <= 1'b0;
            err_ovf_reg   <= 1'b0;
        end else begin
            pix_we_reg   <= pix_hit & bus.WR_READY;
            pix_x_reg    <= bus.H_CNT - x0s;
            pix_y_reg    <= bus.V_CNT - y0s;
            cap_done_reg <= cap_evt;
            if (cap_evt) frame_cnt_reg <= frame_cnt_reg + 1'b1;
            // A new error event outranks a same-cycle clear request.
            if (to_hit)         err_to_reg <= 1'b1;
            else if (clr_flags) err_to_reg <= 1'b0;
            if (pix_hit && !bus.WR_READY) err_ovf_reg <= 1'b1;
            else if (clr_flags)           err_ovf_reg <= 1'b0;
        end
    end

    assign bus.PIX_WE    = pix_we_reg;
    assign bus.PIX_X     = pix_x_reg;
    assign bus.PIX_Y     = pix_y_reg;
    assign bus.BUSY      = busy;
    assign bus.CAP_DONE  = cap_done_reg;
    assign bus.ERR_TO    = err_to_reg;
    assign bus.ERR_OVF   = err_ovf_reg;
    assign bus.H_LEN     = h_len_reg;
    assign bus.V_LEN     = v_len_reg;
    assign bus.FRAME_CNT = frame_cnt_reg;

endmodule

// File: tb/tb_roi_capture_ctrl.sv
// Bench for roi_capture_ctrl: scoreboarded pixel stream, a boundary vector
// table, and hand sequences for continuous, abort, timeout and reset cases.
`timescale 1ns/1ps
module tb_roi_capture_ctrl;
    import roi_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    roi_capture_ctrl_if #(.CNT_W(CNT_W)) bus ();
    roi_capture_ctrl_if #(.CNT_W(CNT_W)) bus_to ();

    roi_capture_ctrl #(.CNT_W(CNT_W), .TO_W(24), .TIMEOUT(24'd100000),
                       .DEF_X0(16'd0), .DEF_Y0(16'd0), .DEF_SIZE(16'd224))
        dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));

    roi_capture_ctrl #(.CNT_W(CNT_W), .TO_W(24), .TIMEOUT(24'd1000),
                       .DEF_X0(16'd0), .DEF_Y0(16'd0), .DEF_SIZE(16'd224))
        dut_to (.CLK(CLK), .RESET_N(RESET_N), .bus(bus_to));

    assign bus_to.VS        = bus.VS;
    assign bus_to.HS        = bus.HS;
    assign bus_to.DE        = bus.DE;
    assign bus_to.H_CNT     = bus.H_CNT;
    assign bus_to.V_CNT     = bus.V_CNT;
    assign bus_to.CFG_WE    = bus.CFG_WE;
    assign bus_to.CFG_ADDR  = bus.CFG_ADDR;
    assign bus_to.CFG_WDATA = bus.CFG_WDATA;
    assign bus_to.START     = bus.START;
    assign bus_to.ABORT     = bus.ABORT;
    assign bus_to.WR_READY  = bus.WR_READY;

    typedef struct packed { logic [15:0] x; logic [15:0] y; } pix_t;
    typedef struct { int h; int v; logic de; logic rdy; logic we; int x; int y; } vec_t;

    pix_t exp_q[$];
    int   checks = 0, failures = 0;
    int   pix_cnt = 0, cap_cnt = 0, cap_to_cnt = 0;
    logic exp_cap = 1'b0;
    int   ex0 = 0, ey0 = 0, esize = 0;
    int   pix_base, cap_base, cap_to_base;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic bit win(input int h, input int v);
        return (h >= ex0) && (h < ex0 + esize) && (v >= ey0) && (v < ey0 + esize);
    endfunction

    // Scoreboard: every PIX_WE must match the oldest outstanding expected pixel.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (bus.PIX_WE) begin
                pix_cnt++;
                check("pix_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) check("pix_xy", {bus.PIX_X, bus.PIX_Y}, exp_q.pop_front());
            end
            if (bus.CAP_DONE)    cap_cnt++;
            if (bus_to.CAP_DONE) cap_to_cnt++;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_time_limit actual=expired expected=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_pix(input int h, input int v, input logic de, input logic rdy);
        bus.H_CNT = 16'(h);
        bus.V_CNT = 16'(v);
        bus.DE = de;
        bus.WR_READY = rdy;
        if (exp_cap && de && rdy && win(h, v)) exp_q.push_back({16'(h - ex0), 16'(v - ey0)});
        tick();
    endtask

    // Row-major scan; the first 'drop' in-window pixels see WR_READY low.
    task automatic raster(input int x_lo, input int x_hi, input int y_lo, input int y_hi, input int drop);
        int dropped = 0;
        logic rdy;
        for (int y = y_lo; y <= y_hi; y++) begin
            for (int x = x_lo; x <= x_hi; x++) begin
                rdy = 1'b1;
                if (win(x, y) && dropped < drop) begin
                    rdy = 1'b0;
                    dropped++;
                end
                drive_pix(x, y, 1'b1, rdy);
            end
        end
        bus.DE = 1'b0;
        bus.WR_READY = 1'b1;
        $display("raster x=%0d..%0d y=%0d..%0d dropped=%0d", x_lo, x_hi, y_lo, y_hi, dropped);
    endtask

    task automatic vs_pulse();
        bus.VS = 1'b1; bus.HS = 1'b1; bus.DE = 1'b0;
        bus.H_CNT = 16'd800; bus.V_CNT = 16'd480;
        tick();
        bus.VS = 1'b0; bus.HS = 1'b0;
        tick();
        $display("vsync frame boundary");
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        bus.CFG_WE = 1'b1; bus.CFG_ADDR = a; bus.CFG_WDATA = d;
        tick();
        bus.CFG_WE = 1'b0;
        $display("cfg write addr=%0d data=0x%04h", a, d);
    endtask

    task automatic start_pulse();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        $display("start pulse");
    endtask

    initial begin
        bus.VS = 0; bus.HS = 0; bus.DE = 0; bus.H_CNT = '0; bus.V_CNT = '0;
        bus.CFG_WE = 0; bus.CFG_ADDR = '0; bus.CFG_WDATA = '0;
        bus.START = 0; bus.ABORT = 0; bus.WR_READY = 1;

        vecs[0] = '{11, 20, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{12, 20, 1'b1, 1'b1, 1'b1, 0, 0};
        vecs[2] = '{15, 23, 1'b1, 1'b1, 1'b1, 3, 3};
        vecs[3] = '{16, 23, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[4] = '{15, 24, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[5] = '{12, 19, 1'b1, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{13, 21, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[7] = '{14, 22, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[8] = '{14, 22, 1'b1, 1'b1, 1'b1, 2, 2};

        repeat (3) tick();
        check("reset_busy", bus.BUSY, 0);
        check("reset_pix_we", bus.PIX_WE, 0);
        check("reset_cap_done", bus.CAP_DONE, 0);
        check("reset_err_to", bus.ERR_TO, 0);
        check("reset_err_ovf", bus.ERR_OVF, 0);
        check("reset_h_len", bus.H_LEN, 0);
        check("reset_v_len", bus.V_LEN, 0);
        check("reset_frame_cnt", bus.FRAME_CNT, 0);
        RESET_N = 1'b1;
        tick();

        // Auto-centred 224x224 ROI in an 800x480 frame.
        cfg_write(ADDR_CTRL, 16'h0001);
        vs_pulse();
        check("meas_h_len", bus.H_LEN, 800);
        check("meas_v_len", bus.V_LEN, 480);
        start_pulse();
        check("auto_busy_arm", bus.BUSY, 1);
        vs_pulse();
        ex0 = 288; ey0 = 128; esize = 224; exp_cap = 1'b1;
        pix_base = pix_cnt; cap_base = cap_cnt;
        raster(286, 513, 126, 353, 0);
        exp_cap = 1'b0;
        vs_pulse();
        check("auto_pix_count", pix_cnt - pix_base, 50176);
        check("auto_queue_empty", exp_q.size(), 0);
        check("auto_cap_done", cap_cnt - cap_base, 1);
        check("auto_frame_cnt", bus.FRAME_CNT, 1);
        check("auto_idle", bus.BUSY, 0);

        // Continuous manual window with a mid-frame X0 rewrite.
        cfg_write(ADDR_X0, 16'd10);
        cfg_write(ADDR_Y0, 16'd20);
        cfg_write(ADDR_SIZE, 16'd4);
        cfg_write(ADDR_CTRL, 16'h0002);
        vs_pulse();
        start_pulse();
        vs_pulse();
        ex0 = 10; ey0 = 20; esize = 4; exp_cap = 1'b1;
        cap_base = cap_cnt;
        pix_base = pix_cnt;
        raster(8, 15, 18, 21, 0);
        cfg_write(ADDR_X0, 16'd12);
        raster(8, 15, 22, 25, 0);
        vs_pulse();
        check("cont_f1_pix", pix_cnt - pix_base, 16);
        check("cont_f1_busy", bus.BUSY, 1);
        ex0 = 12;
        pix_base = pix_cnt;
        raster(10, 17, 18, 25, 0);
        vs_pulse();
        check("cont_f2_pix", pix_cnt - pix_base, 16);
        pix_base = pix_cnt;
        raster(10, 17, 18, 25, 5);
        check("ovf_set", bus.ERR_OVF, 1);
        vs_pulse();
        check("cont_f3_pix", pix_cnt - pix_base, 11);
        check("cont_cap_done", cap_cnt - cap_base, 3);
        check("cont_frame_cnt", bus.FRAME_CNT, 4);
        check("cont_busy", bus.BUSY, 1);
        check("cont_queue_empty", exp_q.size(), 0);
        cfg_write(ADDR_CTRL, 16'h0082);
        check("ovf_cleared", bus.ERR_OVF, 0);

        // Window boundary vectors, still in continuous capture.
        cap_base = cap_cnt;
        for (int i = 0; i < 9; i++) begin
            drive_pix(vecs[i].h, vecs[i].v, vecs[i].de, vecs[i].rdy);
            check($sformatf("vec%0d_we", i), bus.PIX_WE, vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("vec%0d_x", i), bus.PIX_X, vecs[i].x);
                check($sformatf("vec%0d_y", i), bus.PIX_Y, vecs[i].y);
            end
        end
        bus.DE = 1'b0;
        check("vec_ovf_set", bus.ERR_OVF, 1);

        // Abort mid-capture.
        bus.ABORT = 1'b1;
        drive_pix(13, 21, 1'b1, 1'b1);
        bus.ABORT = 1'b0;
        exp_cap = 1'b0;
        check("abort_busy", bus.BUSY, 0);
        drive_pix(13, 22, 1'b1, 1'b1);
        check("abort_pix_stop", bus.PIX_WE, 0);
        bus.DE = 1'b0;
        vs_pulse();
        check("abort_no_cap_done", cap_cnt - cap_base, 0);
        check("abort_queue_empty", exp_q.size(), 0);

        // START and ABORT together.
        bus.START = 1'b1; bus.ABORT = 1'b1;
        tick();
        bus.START = 1'b0; bus.ABORT = 1'b0;
        check("start_abort_idle", bus.BUSY, 0);
        vs_pulse();
        check("start_abort_still_idle", bus.BUSY, 0);

        // Watchdog with VS stuck low, on the TIMEOUT=1000 instance.
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        cap_to_base = cap_to_cnt;
        start_pulse();
        repeat (999) @(posedge CLK);
        #1;
        check("to_not_yet", bus_to.ERR_TO, 0);
        check("to_busy_before", bus_to.BUSY, 1);
        tick();
        check("to_err_to", bus_to.ERR_TO, 1);
        check("to_idle", bus_to.BUSY, 0);
        check("to_no_cap_done", cap_to_cnt - cap_to_base, 0);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;

        // Asynchronous reset in the middle of a capture.
        cfg_write(ADDR_X0, 16'd10);
        cfg_write(ADDR_Y0, 16'd20);
        cfg_write(ADDR_SIZE, 16'd4);
        cfg_write(ADDR_CTRL, 16'h0002);
        vs_pulse();
        start_pulse();
        vs_pulse();
        ex0 = 10; ey0 = 20; esize = 4; exp_cap = 1'b1;
        raster(8, 15, 18, 25, 5);
        vs_pulse();
        check("pre_rst_frame_cnt", bus.FRAME_CNT, 1);
        drive_pix(11, 21, 1'b1, 1'b1);
        drive_pix(12, 21, 1'b1, 1'b1);
        check("pre_rst_pix_we", bus.PIX_WE, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst_pix_we", bus.PIX_WE, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_err_ovf", bus.ERR_OVF, 0);
        check("rst_frame_cnt", bus.FRAME_CNT, 0);
        check("rst_h_len", bus.H_LEN, 0);
        check("rst_v_len", bus.V_LEN, 0);
        exp_q.delete();
        exp_cap = 1'b0;
        bus.DE = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();

        // First frame after reset runs on the default 224-pixel window at 0,0.
        start_pulse();
        vs_pulse();
        ex0 = 0; ey0 = 0; esize = 224; exp_cap = 1'b1;
        pix_base = pix_cnt; cap_base = cap_cnt;
        raster(0, 2, 0, 1, 0);
        raster(221, 225, 222, 224, 0);
        exp_cap = 1'b0;
        vs_pulse();
        check("def_pix_count", pix_cnt - pix_base, 12);
        check("def_queue_empty", exp_q.size(), 0);
        check("def_cap_done", cap_cnt - cap_base, 1);
        check("def_frame_cnt", bus.FRAME_CNT, 1);
        check("def_idle", bus.BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
